// File: rtl/oclib_pkg.sv
// Shared definitions for the oclib blocks: boolean constants, reset sequencer
// state type and counter sizing helper.
package oclib_pkg;

  localparam bit False = 1'b0;
  localparam bit True  = 1'b1;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } oclib_reset_seq_state_e;

  // Width of a down-counter that must hold values 0..max(a,b)-1; never below 1 bit.
  function automatic int oclib_reset_seq_cnt_width(input int min_assert, input int stage_gap);
    int span;
    span = (min_assert > stage_gap) ? min_assert : stage_gap;
    return (span > 1) ? $clog2(span) : 1;
  endfunction

endpackage

// File: rtl/oclib_reset_sequencer.sv
// Merges reset requests into one ordered sequence: all domains assert together,
// are held, then release one at a time starting with domain 0.
module oclib_reset_sequencer
  import oclib_pkg::*;
#(
  parameter int NumRequesters   = 2,
  parameter int NumDomains      = 3,
  parameter int MinAssertCycles = 16,
  parameter int StageGapCycles  = 4,
  parameter bit ActiveLow       = oclib_pkg::False,
  parameter int CountWidth      = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NumRequesters-1:0] resetRequest,
  output logic [NumDomains-1:0]    resetOut,
  output logic                     busy,
  output logic                     done,
  output logic [NumRequesters-1:0] resetCause,
  output logic [CountWidth-1:0]    resetCount
);

  localparam int CntW = oclib_reset_seq_cnt_width(MinAssertCycles, StageGapCycles);
  localparam logic [CntW-1:0]       HoldLoad = CntW'(MinAssertCycles - 1);
  localparam logic [CntW-1:0]       GapLoad  = CntW'(StageGapCycles - 1);
  localparam logic [NumDomains-1:0] Dom0Mask = NumDomains'(1);
  // Output level for a domain that is still held in reset.
  localparam logic [NumDomains-1:0] HeldLevel = ActiveLow ? {NumDomains{1'b0}} : {NumDomains{1'b1}};

  oclib_reset_seq_state_e   state_r, state_s;
  logic [CntW-1:0]          cnt_r, cnt_s;
  logic [NumDomains-1:0]    released_r, released_s;
  logic [NumRequesters-1:0] cause_r, cause_s;
  logic [CountWidth-1:0]    count_r, count_s;
  logic [NumDomains-1:0]    out_r;
  logic                     busy_r;
  logic                     done_r;
  logic                     done_s;
  logic                     req_any_s;

  assign req_any_s = |resetRequest;

  // Next-state, shared hold/gap counter and bookkeeping for cause/count.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    released_s = released_r;
    cause_s    = cause_r;
    count_s    = count_r;
    done_s     = 1'b0;
    case (state_r)
      ASSERT: begin
        if (req_any_s) begin
          cnt_s   = HoldLoad;
          cause_s = cause_r | resetRequest;
        end else if (cnt_r == '0) begin
          released_s = Dom0Mask;
          cnt_s      = GapLoad;
          if (released_s[NumDomains-1]) begin
            state_s = RUN;
            done_s  = 1'b1;
          end else begin
            state_s = RELEASE;
          end
        end else begin
          cnt_s = cnt_r - CntW'(1);
        end
      end
      RELEASE: begin
        if (req_any_s) begin
          state_s    = ASSERT;
          cnt_s      = HoldLoad;
          released_s = '0;
          cause_s    = resetRequest;
          count_s    = (count_r == '1) ? count_r : count_r + CountWidth'(1);
        end else if (cnt_r == '0) begin
          // Release mask is a thermometer code growing from domain 0 upward.
          released_s = (released_r << 1) | Dom0Mask;
          cnt_s      = GapLoad;
          if (released_s[NumDomains-1]) begin
            state_s = RUN;
            done_s  = 1'b1;
          end else begin
            state_s = RELEASE;
          end
        end else begin
          cnt_s = cnt_r - CntW'(1);
        end
      end
      RUN: begin
        if (req_any_s) begin
          state_s    = ASSERT;
          cnt_s      = HoldLoad;
          released_s = '0;
          cause_s    = resetRequest;
          count_s    = (count_r == '1) ? count_r : count_r + CountWidth'(1);
        end else begin
          state_s = RUN;
        end
      end
      default: begin
        state_s    = ASSERT;
        cnt_s      = HoldLoad;
        released_s = '0;
      end
    endcase
  end

  // State and output registers; reset clears history instead of recording it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= ASSERT;
      cnt_r      <= HoldLoad;
      released_r <= '0;
      cause_r    <= '0;
      count_r    <= '0;
      out_r      <= HeldLevel;
      busy_r     <= 1'b1;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      released_r <= released_s;
      cause_r    <= cause_s;
      count_r    <= count_s;
      out_r      <= HeldLevel ^ released_s;
      busy_r     <= (state_s != RUN);
      done_r     <= done_s;
    end
  end

  assign resetOut   = out_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign resetCause = cause_r;
  assign resetCount = count_r;

endmodule

// File: tb/tb_oclib_reset_sequencer.sv
// Scoreboard bench for oclib_reset_sequencer: a default instance and a
// one-domain, active-low, 2-bit-count instance share the same stimulus.
module tb_oclib_reset_sequencer;
  import oclib_pkg::*;

  localparam int M = 16;
  localparam int G = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset = 1'b1;
  logic [1:0] req   = 2'b00;

  logic [2:0]  out_a;
  logic        busy_a, done_a;
  logic [1:0]  cause_a;
  logic [15:0] count_a;
  logic [0:0]  out_b;
  logic        busy_b, done_b;
  logic [1:0]  cause_b;
  logic [1:0]  count_b;

  oclib_reset_sequencer #(
    .NumRequesters(2), .NumDomains(3), .MinAssertCycles(M), .StageGapCycles(G),
    .ActiveLow(oclib_pkg::False), .CountWidth(16)
  ) dut_a (
    .clock(clock), .reset(reset), .resetRequest(req), .resetOut(out_a),
    .busy(busy_a), .done(done_a), .resetCause(cause_a), .resetCount(count_a)
  );

  oclib_reset_sequencer #(
    .NumRequesters(2), .NumDomains(1), .MinAssertCycles(M), .StageGapCycles(G),
    .ActiveLow(oclib_pkg::True), .CountWidth(2)
  ) dut_b (
    .clock(clock), .reset(reset), .resetRequest(req), .resetOut(out_b),
    .busy(busy_b), .done(done_b), .resetCause(cause_b), .resetCount(count_b)
  );

  typedef struct packed {
    logic [2:0]  out;
    logic        busy;
    logic        done;
    logic [1:0]  cause;
    logic [15:0] count;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int total = 0;
  int bad   = 0;

  // Reference model: k = edges since the last edge that sampled a request or reset.
  int         k[2];
  logic [1:0] m_cause[2];
  int         m_count[2];
  int         nd[2]   = '{3, 1};
  int         cmax[2] = '{65535, 3};
  bit         al[2]   = '{1'b0, 1'b1};

  task automatic step_model(input int n, input logic rst, input logic [1:0] r, output exp_t e);
    bit rel;
    if (rst) begin
      k[n] = 0; m_cause[n] = 2'b00; m_count[n] = 0;
    end else if (r != 2'b00) begin
      if (k[n] >= M) begin
        m_cause[n] = r;
        m_count[n] = (m_count[n] < cmax[n]) ? m_count[n] + 1 : m_count[n];
      end else begin
        m_cause[n] = m_cause[n] | r;
      end
      k[n] = 0;
    end else if (k[n] < 1000) begin
      k[n] = k[n] + 1;
    end
    e = '0;
    for (int i = 0; i < nd[n]; i++) begin
      rel = (k[n] >= M + i * G);
      e.out[i] = al[n] ? rel : !rel;
    end
    e.busy  = (k[n] < M + (nd[n] - 1) * G);
    e.done  = (k[n] == M + (nd[n] - 1) * G);
    e.cause = m_cause[n];
    e.count = 16'(m_count[n]);
  endtask

  task automatic chk(input string name, input int inst, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s inst%0d t=%0t got=%h want=%h", name, inst, $time, got, want);
    end
  endtask

  task automatic cyc(input logic rst, input logic [1:0] r, input int n);
    exp_t e;
    repeat (n) begin
      @(negedge clock);
      reset = rst;
      req   = r;
      step_model(0, rst, r, e); q_a.push_back(e);
      step_model(1, rst, r, e); q_b.push_back(e);
    end
  endtask

  // Monitor: after each active edge, compare every output against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        chk("resetOut", 0, 32'(out_a), 32'(e.out));
        chk("busy", 0, 32'(busy_a), 32'(e.busy));
        chk("done", 0, 32'(done_a), 32'(e.done));
        chk("resetCause", 0, 32'(cause_a), 32'(e.cause));
        chk("resetCount", 0, 32'(count_a), 32'(e.count));
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        chk("resetOut", 1, 32'(out_b), 32'(e.out[0]));
        chk("busy", 1, 32'(busy_b), 32'(e.busy));
        chk("done", 1, 32'(done_b), 32'(e.done));
        chk("resetCause", 1, 32'(cause_b), 32'(e.cause));
        chk("resetCount", 1, 32'(count_b), 32'(e.count[1:0]));
      end
    end
  end

  initial begin
    int n_len;
    logic [1:0] r;
    // Power-on, single pulse, long hold, mid-release retrigger, simultaneous requests.
    cyc(1'b1, 2'b00, 5);
    cyc(1'b0, 2'b00, 30);
    cyc(1'b0, 2'b10, 1);
    cyc(1'b0, 2'b00, 30);
    cyc(1'b0, 2'b01, 30);
    cyc(1'b0, 2'b00, 30);
    cyc(1'b0, 2'b10, 1);
    cyc(1'b0, 2'b00, 16);
    cyc(1'b0, 2'b01, 1);
    cyc(1'b0, 2'b00, 30);
    cyc(1'b0, 2'b11, 1);
    cyc(1'b0, 2'b00, 7);
    cyc(1'b0, 2'b01, 1);
    cyc(1'b0, 2'b00, 30);
    // Random bursts, gaps and occasional reset.
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 19) == 0) begin
        cyc(1'b1, 2'($urandom_range(0, 3)), $urandom_range(1, 3));
      end else begin
        r = 2'($urandom_range(1, 3));
        cyc(1'b0, r, $urandom_range(1, 3));
      end
      n_len = $urandom_range(0, 40);
      if (n_len > 0) cyc(1'b0, 2'b00, n_len);
    end
    cyc(1'b0, 2'b00, 30);
    @(negedge clock);
    @(negedge clock);
    chk("queue_drained", 0, 32'(q_a.size() + q_b.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/oclib_reset_sequencer.md
Name: oclib_reset_sequencer

Overview:
- Synthesizable reset controller that merges several reset request sources into one ordered reset sequence for multiple downstream domains.
- All domain resets assert together and are held for a minimum time, then released one domain at a time (domain 0 first) with a fixed gap between releases.
- Sits at the top of a chip or testbench. It replaces free-running startup reset generation, and lets software, watchdog or debug logic re-trigger a full reset at runtime.

Parameters:
- NumRequesters, 2, number of reset request inputs (>=1)
- NumDomains, 3, number of sequenced reset outputs (>=1)
- MinAssertCycles, 16, cycles all domain resets stay asserted after the last active request (>=1)
- StageGapCycles, 4, cycles between release of domain i and domain i+1 (>=1)
- ActiveLow, oclib_pkg::False, polarity of resetOut only; all other signals are active-high
- CountWidth, 16, width of resetCount

Ports:
- clock  input  1  single clock for everything
- reset  input  1  synchronous, active-high reset; acts as an implicit highest-priority request
- resetRequest  input  NumRequesters  level-sensitive requests, sampled each rising edge
- resetOut  output  NumDomains  per-domain reset; asserted level is set by ActiveLow
- busy  output  1  high while any domain is held in reset
- done  output  1  one-cycle pulse when the last domain releases
- resetCause  output  NumRequesters  sticky OR of requests seen during the current or most recent sequence
- resetCount  output  CountWidth  saturating count of sequences started by resetRequest

Behaviour:
- States:
  - ASSERT: all domains in reset, hold counter running.
  - RELEASE: stepping through domains.
  - RUN: all domains released.
- Reset values (reset high): state=ASSERT; resetOut all asserted; busy=1; done=0; resetCause=0; resetCount=0; hold counter=MinAssertCycles-1.
- ASSERT:
  - Any request high (or reset high) reloads the hold counter to MinAssertCycles-1.
  - Otherwise the counter decrements.
  - When the counter is 0 and no request is high, the next edge moves to RELEASE and deasserts resetOut[0].
  - Result: resetOut[0] deasserts exactly MinAssertCycles edges after the last edge that sampled a request.
- RELEASE:
  - The gap counter loads StageGapCycles-1 at each domain release.
  - When the gap counter expires, the next domain is released.
  - Domain i therefore deasserts i*StageGapCycles edges after domain 0.
  - On the edge that releases domain NumDomains-1: state becomes RUN and done pulses high for that one cycle.
  - If NumDomains=1, RUN and done occur on the same edge as the domain 0 release.
- RUN: resetOut all deasserted; busy=0.
- A request seen in RELEASE or RUN re-enters ASSERT on the next edge:
  - all domains re-assert together, including already-released ones;
  - the hold counter reloads;
  - resetCause clears, then captures that request;
  - resetCount increments (saturates at all-ones).
- A request seen in ASSERT extends the hold. It does not increment resetCount and ORs into resetCause.
- Assertion of the reset port: same as above, except resetCause and resetCount clear instead of capturing or incrementing.
- Simultaneous requests: all set bits are captured in resetCause; the count increments once.
- Request high on the same edge the hold counter reaches 0: the hold extends and no release occurs.
- busy = (state != RUN). It changes on the same edges as the resetOut transitions.
- All outputs are registered. There is no combinational path from resetRequest to any output.

Decomposition:
- In oclib_pkg, add:
  - the state enum type oclib_reset_seq_state_e (ASSERT/RELEASE/RUN);
  - a helper that computes clog2-safe counter widths for MinAssertCycles and StageGapCycles.
- No sub-module is needed. The hold and gap counters share one down-counter register sized to max(MinAssertCycles, StageGapCycles).

Test Plan (defaults unless stated):
- Power-on: reset high 5 cycles, then low; no requests. → resetOut[0..2] deassert at edges 16/20/24 after the last reset edge; done pulses at edge 24; busy falls at edge 24; resetCount=0.
- From RUN, pulse resetRequest[1] for 1 cycle. → next edge resetOut=3'b111; resetCause=2'b10; resetCount=1; release at +16/+20/+24 edges from the request edge.
- From RUN, hold resetRequest[0] high 30 cycles. → resetOut stays asserted throughout; domain 0 releases 16 edges after the last high sample; resetCount=1.
- Mid-release: request during the cycle after resetOut[0] releases. → all three outputs re-assert next edge; resetCount increments; full 16/20/24 timing restarts.
- Simultaneous: both requests high 1 cycle, then resetRequest[0] again 8 cycles later while in ASSERT. → resetCause=2'b11; resetCount +1 only; hold extended; release 16 edges after the second request.
- Saturation (CountWidth=2), and ActiveLow=True with NumDomains=1:
  - After 5 requested sequences, resetCount=3.
  - With ActiveLow=True and NumDomains=1, resetOut starts at 0 and goes to 1 at release; done coincides with that edge.
